// File: rtl/insn_seq_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM state encoding
// and instruction field positions.
package insn_seq_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_MOV  = 4'h9;
    localparam logic [3:0] OP_BNZ  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int DST_MSB  = 11;
    localparam int DST_LSB  = 8;
    localparam int SRC0_MSB = 7;
    localparam int SRC0_LSB = 4;
    localparam int SRC1_MSB = 3;
    localparam int SRC1_LSB = 0;
    localparam int IMM_MSB  = 7;
    localparam int IMM_LSB  = 0;

    // Opcodes 1..9 produce a register write-back.
    function automatic logic is_write_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_MOV);
    endfunction

endpackage

// File: rtl/insn_sequencer_alu.sv
// Combinational ALU for the write-back opcodes (ADD..MOV); arithmetic is modulo 256.
module seq_alu
    import insn_seq_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] imm8,
    output logic [7:0] result
);

    always_comb begin
        result = '0;
        case (opcode)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL:  result = {a[6:0], 1'b0};
            OP_SHR:  result = {1'b0, a[7:1]};
            OP_LDI:  result = imm8;
            OP_MOV:  result = a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/insn_sequencer.sv
// Fetch/decode/execute controller driving the 16x8 register file.
// Branches (BNZ/JMP) exist only when INSN_SEQ_BRANCH_EN is defined; otherwise they run as NOP.
module insn_sequencer
    import insn_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [3:0]  rf_src0,
    output logic [3:0]  rf_src1,
    input  logic [7:0]  rf_rdata0,
    input  logic [7:0]  rf_rdata1,
    output logic        rf_we,
    output logic [3:0]  rf_dst,
    output logic [7:0]  rf_wdata,
    output logic        busy,
    output logic        halted,
    output logic [7:0]  pc
);

    state_t      state_reg, state_next;
    logic [7:0]  pc_reg, pc_next, pc_inc, exec_pc;
    logic [15:0] ir_reg, ir_next;
    logic        imem_req_reg, imem_req_next;
    logic [7:0]  imem_addr_reg;
    logic [3:0]  rf_src0_reg, rf_src0_next, rf_src1_reg, rf_src1_next;
    logic [3:0]  rf_dst_reg, rf_dst_next;
    logic        rf_we_reg, rf_we_next;
    // Doubles as the result register: loaded in EXEC, visible only during WB.
    logic [7:0]  rf_wdata_reg, rf_wdata_next;
    logic [3:0]  opcode;
    logic [7:0]  imm8, alu_result;

    assign opcode = ir_reg[OPC_MSB:OPC_LSB];
    assign imm8   = ir_reg[IMM_MSB:IMM_LSB];
    assign pc_inc = pc_reg + 8'd1;

`ifdef INSN_SEQ_BRANCH_EN
    logic branch_taken;
    assign branch_taken = (opcode == OP_JMP) || ((opcode == OP_BNZ) && (rf_rdata0 != 8'd0));
    assign exec_pc      = branch_taken ? imm8 : pc_inc;
`else
    assign exec_pc      = pc_inc;
`endif

    seq_alu u_alu (
        .opcode (opcode),
        .a      (rf_rdata0),
        .b      (rf_rdata1),
        .imm8   (imm8),
        .result (alu_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            pc_reg        <= '0;
            ir_reg        <= '0;
            imem_req_reg  <= 1'b0;
            imem_addr_reg <= '0;
            rf_src0_reg   <= '0;
            rf_src1_reg   <= '0;
            rf_dst_reg    <= '0;
            rf_we_reg     <= 1'b0;
            rf_wdata_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            ir_reg        <= ir_next;
            imem_req_reg  <= imem_req_next;
            imem_addr_reg <= pc_next;
            rf_src0_reg   <= rf_src0_next;
            rf_src1_reg   <= rf_src1_next;
            rf_dst_reg    <= rf_dst_next;
            rf_we_reg     <= rf_we_next;
            rf_wdata_reg  <= rf_wdata_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        case (state_reg)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_next = ST_FETCH;
                    pc_next    = '0;
                end
            end
            ST_FETCH:  if (imem_ack) state_next = ST_DECODE;
            ST_DECODE: state_next = ST_EXEC;
            ST_EXEC: begin
                if (is_write_op(opcode)) begin
                    state_next = ST_WB;
                end else if (opcode == OP_HALT) begin
                    state_next = ST_HALT;
                end else begin
                    state_next = ST_FETCH;
                    pc_next    = exec_pc;
                end
            end
            ST_WB: begin
                state_next = ST_FETCH;
                pc_next    = pc_inc;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Registered outputs are computed from the next state so they line up with it.
    always_comb begin
        ir_next       = ir_reg;
        rf_src0_next  = rf_src0_reg;
        rf_src1_next  = rf_src1_reg;
        rf_dst_next   = rf_dst_reg;
        imem_req_next = (state_next == ST_FETCH);
        rf_we_next    = (state_next == ST_WB);
        rf_wdata_next = '0;
        if ((state_reg == ST_FETCH) && imem_ack) begin
            ir_next      = imem_data;
            rf_src0_next = (imem_data[OPC_MSB:OPC_LSB] == OP_BNZ) ? imem_data[DST_MSB:DST_LSB]
                                                                  : imem_data[SRC0_MSB:SRC0_LSB];
            rf_src1_next = imem_data[SRC1_MSB:SRC1_LSB];
        end
        if (state_reg == ST_EXEC) begin
            rf_dst_next = ir_reg[DST_MSB:DST_LSB];
        end
        if (state_next == ST_WB) begin
            rf_wdata_next = alu_result;
        end
    end

    assign imem_req  = imem_req_reg;
    assign imem_addr = imem_addr_reg;
    assign rf_src0   = rf_src0_reg;
    assign rf_src1   = rf_src1_reg;
    assign rf_we     = rf_we_reg;
    assign rf_dst    = rf_dst_reg;
    assign rf_wdata  = rf_wdata_reg;
    assign pc        = pc_reg;
    assign busy      = (state_reg != ST_IDLE) && (state_reg != ST_HALT);
    assign halted    = (state_reg == ST_HALT);

endmodule

// File: tb/tb_insn_sequencer.sv
// Randomized bench for insn_sequencer: an ISA-level interpreter predicts fetches,
// write-backs, final pc and cycle count; memory and register file are modelled here.
module tb_insn_sequencer;

`ifdef INSN_SEQ_BRANCH_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, imem_req, imem_ack, rf_we, busy, halted;
    logic [7:0]  imem_addr, rf_rdata0, rf_rdata1, rf_wdata, pc;
    logic [15:0] imem_data;
    logic [3:0]  rf_src0, rf_src1, rf_dst;

    logic [15:0] mem [256];
    logic [7:0]  rf [16];
    logic [7:0]  rf_init [16];

    logic [11:0] exp_wb [$];
    logic [7:0]  exp_fetch [$];
    logic [7:0]  exp_halt_pc;
    int          exp_cycles;

    int   n_checks, n_pass;
    bit   mon_en;
    int   delay_lo, delay_hi, cur_delay, req_cnt, delay_sum, wb_count;
    logic [7:0] req_addr;

    always #5 clk = ~clk;

    assign rf_rdata0 = rf[rf_src0];
    assign rf_rdata1 = rf[rf_src1];

    insn_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .rf_src0   (rf_src0),
        .rf_src1   (rf_src1),
        .rf_rdata0 (rf_rdata0),
        .rf_rdata1 (rf_rdata1),
        .rf_we     (rf_we),
        .rf_dst    (rf_dst),
        .rf_wdata  (rf_wdata),
        .busy      (busy),
        .halted    (halted),
        .pc        (pc)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    // Instruction-set interpreter over mem[] starting at pc 0 with rf_init[].
    task automatic run_model();
        logic [7:0]  r [16];
        logic [7:0]  p, a, b, im, v;
        logic [15:0] w;
        logic [3:0]  op, d;
        bit          done;
        r = rf_init;
        p = 8'd0;
        done = 1'b0;
        exp_wb.delete();
        exp_fetch.delete();
        exp_cycles = 0;
        for (int n = 0; n < 600 && !done; n++) begin
            exp_fetch.push_back(p);
            w  = mem[p];
            op = w[15:12];
            d  = w[11:8];
            a  = r[w[7:4]];
            b  = r[w[3:0]];
            im = w[7:0];
            exp_cycles += 3;
            if (op >= 4'd1 && op <= 4'd9) begin
                case (op)
                    4'd1: v = a + b;
                    4'd2: v = a - b;
                    4'd3: v = a & b;
                    4'd4: v = a | b;
                    4'd5: v = a ^ b;
                    4'd6: v = a << 1;
                    4'd7: v = a >> 1;
                    4'd8: v = im;
                    default: v = a;
                endcase
                r[d] = v;
                exp_wb.push_back({d, v});
                exp_cycles += 1;
                p = p + 8'd1;
            end else if (op == 4'hF) begin
                done = 1'b1;
            end else if (op == 4'hB && BR_EN) begin
                p = im;
            end else if (op == 4'hA && BR_EN && r[d] != 8'd0) begin
                p = im;
            end else begin
                p = p + 8'd1;
            end
        end
        exp_halt_pc = p;
    endtask

    // One clock: act as instruction memory and register file, and monitor outputs.
    task automatic tick();
        logic [11:0] e;
        logic [7:0]  fa;
        logic [31:0] rnd;
        @(negedge clk);
        if (rf_we) begin
            wb_count++;
            if (mon_en) begin
                check_eq("wb_expected", exp_wb.size() != 0, 1);
                if (exp_wb.size() != 0) begin
                    e = exp_wb.pop_front();
                    check_eq("wb_dst", rf_dst, e[11:8]);
                    check_eq("wb_data", rf_wdata, e[7:0]);
                end
            end
            rf[rf_dst] = rf_wdata;
        end else if (mon_en) begin
            check_eq("wdata_idle", rf_wdata, 0);
        end
        rnd = $urandom;
        if (imem_req) begin
            if (req_cnt == 0) req_addr = imem_addr;
            else if (mon_en) check_eq("addr_stable", imem_addr, req_addr);
            if (req_cnt >= cur_delay) begin
                imem_ack  = 1'b1;
                imem_data = mem[imem_addr];
                if (mon_en) begin
                    check_eq("fetch_expected", exp_fetch.size() != 0, 1);
                    if (exp_fetch.size() != 0) begin
                        fa = exp_fetch.pop_front();
                        check_eq("fetch_addr", imem_addr, fa);
                    end
                end
                delay_sum += cur_delay;
                req_cnt   = 0;
                cur_delay = $urandom_range(delay_hi, delay_lo);
            end else begin
                imem_ack  = 1'b0;
                imem_data = rnd[15:0];
                req_cnt++;
            end
        end else begin
            imem_ack  = rnd[16];
            imem_data = rnd[15:0];
            req_cnt   = 0;
        end
    endtask

    task automatic run_program(input int lo, input int hi, input bit poke, output int cycles);
        run_model();
        rf        = rf_init;
        delay_lo  = lo;
        delay_hi  = hi;
        cur_delay = $urandom_range(hi, lo);
        req_cnt   = 0;
        delay_sum = 0;
        wb_count  = 0;
        mon_en    = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 0;
        while (!halted && cycles < 4000) begin
            start = poke && (cycles == 2);
            tick();
            cycles++;
        end
        start = 1'b0;
        check_eq("halted", halted, 1);
        check_eq("busy_after_halt", busy, 0);
        check_eq("halt_pc", pc, exp_halt_pc);
        check_eq("cycles", cycles, exp_cycles + delay_sum);
        check_eq("wb_left", exp_wb.size(), 0);
        check_eq("fetch_left", exp_fetch.size(), 0);
        $display("run: insns=%0d writebacks=%0d cycles=%0d halt_pc=%0h", exp_fetch.size(), wb_count, cycles, pc);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
        for (int i = 0; i < 16; i++) rf_init[i] = 8'h00;
    endtask

    task automatic load_prog_a();
        clear_mem();
        mem[0] = 16'h8105;
        mem[1] = 16'h82FE;
        mem[2] = 16'h1312;
        mem[3] = 16'hF000;
    endtask

    initial begin
        int cyc, c, len, k;
        logic [3:0]  op;
        logic [31:0] r32;
        logic [7:0]  tgt;
        n_checks = 0; n_pass = 0;
        rst = 1'b1; start = 1'b0; mon_en = 1'b0;
        delay_lo = 0; delay_hi = 0; cur_delay = 0; req_cnt = 0; delay_sum = 0; wb_count = 0;
        imem_ack = 1'b0; imem_data = '0; req_addr = '0;
        clear_mem();
        rf = rf_init;
        tick();
        tick();
        check_eq("rst_pc", pc, 0);
        check_eq("rst_imem_req", imem_req, 0);
        check_eq("rst_imem_addr", imem_addr, 0);
        check_eq("rst_rf_we", rf_we, 0);
        check_eq("rst_rf_dst", rf_dst, 0);
        check_eq("rst_rf_wdata", rf_wdata, 0);
        check_eq("rst_rf_src0", rf_src0, 0);
        check_eq("rst_rf_src1", rf_src1, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_halted", halted, 0);
        rst = 1'b0;
        tick();

        // LDI/LDI/ADD/HALT with zero-wait memory.
        load_prog_a();
        run_program(0, 0, 1'b0, cyc);
        check_eq("progA_cycles", cyc, 15);
        check_eq("progA_r3", rf[3], 8'h03);
        check_eq("progA_wbs", wb_count, 3);

        // Same program, every fetch acknowledged three cycles late.
        run_program(3, 3, 1'b0, cyc);
        check_eq("progA_slow_cycles", cyc, 15 + 4 * 3);

        // Reset while a write-back is in flight.
        mon_en = 1'b0;
        rf = rf_init;
        delay_lo = 0; delay_hi = 0; cur_delay = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (!rf_we && c < 50) begin
            tick();
            c++;
        end
        check_eq("midwb_we_seen", rf_we, 1);
        rst = 1'b1;
        tick();
        check_eq("midwb_rf_we", rf_we, 0);
        check_eq("midwb_pc", pc, 0);
        check_eq("midwb_busy", busy, 0);
        check_eq("midwb_halted", halted, 0);
        check_eq("midwb_imem_req", imem_req, 0);
        rst = 1'b0;
        tick();
        run_program(0, 1, 1'b0, cyc);

        // Countdown loop: SUB repeats only when BNZ is built in.
        clear_mem();
        mem[0] = 16'h8103;
        mem[1] = 16'h2112;
        mem[2] = 16'hA101;
        mem[3] = 16'hF000;
        rf_init[2] = 8'h01;
        run_program(0, 2, 1'b0, cyc);
        check_eq("loop_wbs", wb_count, BR_EN ? 4 : 2);
        check_eq("loop_r1", rf[1], BR_EN ? 8'h00 : 8'h02);

        // JMP to 0xFF region, NOP at 0xFF wraps to 0x00; start poked while busy.
        clear_mem();
        mem[8'h00] = 16'hA110;
        mem[8'h01] = 16'hF000;
        mem[8'h10] = 16'hB0FE;
        mem[8'hFE] = 16'h8100;
        mem[8'hFF] = 16'h0000;
        rf_init[1] = 8'h07;
        run_program(0, 1, 1'b1, cyc);

        // Random straight-line programs with forward-only branches.
        for (int t = 0; t < 25; t++) begin
            clear_mem();
            len = $urandom_range(14, 4);
            for (int i = 0; i < len; i++) begin
                k   = $urandom_range(14, 0);
                r32 = $urandom;
                if (k <= 9)       op = 4'(k);
                else if (k == 10) op = 4'hC;
                else if (k == 11) op = 4'hD;
                else if (k == 12) op = 4'hE;
                else if (k == 13) op = 4'hA;
                else              op = 4'hB;
                mem[i] = {op, r32[11:0]};
                if (op == 4'hA || op == 4'hB) begin
                    tgt = 8'($urandom_range(len, i + 1));
                    mem[i] = {op, r32[11:8], tgt};
                end
            end
            for (int i = 0; i < 16; i++) begin
                r32 = $urandom;
                rf_init[i] = r32[7:0];
            end
            run_program(0, 3, 1'b0, cyc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
